// File: rtl/c432_key_ctrl.sv
// Key-loading and query sequencer for a logic-locked c432 core: serial key shift/commit,
// registered pattern launch, fixed settle window and a held response handshake.
module c432_key_ctrl #(
    parameter int unsigned KEY_W  = 2,
    parameter int unsigned PI_W   = 36,
    parameter int unsigned PO_W   = 7,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_bit,
    input  logic              key_bit_vld,
    input  logic              key_commit,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [PI_W-1:0]   q_pi,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [PO_W-1:0]   r_po,
    output logic [PI_W-1:0]   core_pi,
    output logic [KEY_W-1:0]  core_key,
    input  logic [PO_W-1:0]   core_po,
    output logic              key_loaded,
    output logic              key_err
);

    localparam int unsigned CNT_W = $clog2(KEY_W + 1);
    localparam int unsigned SET_W = 4;

    typedef enum logic [1:0] {NOKEY, IDLE, APPLY, RESP} state_t;

    state_t             state, state_n;
    logic [KEY_W-1:0]   shadow, shadow_n;
    logic [CNT_W-1:0]   key_cnt, key_cnt_n;
    logic               pend, pend_n;
    logic [KEY_W-1:0]   pend_key, pend_key_n;
    logic [SET_W-1:0]   settle, settle_n;
    logic [KEY_W-1:0]   core_key_n;
    logic [PI_W-1:0]    core_pi_n;
    logic [PO_W-1:0]    r_po_n;
    logic               r_valid_n;
    logic               q_ready_n;
    logic               key_loaded_n;
    logic               key_err_n;
    logic               commit_ok;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NOKEY;
            shadow     <= '0;
            key_cnt    <= '0;
            pend       <= 1'b0;
            pend_key   <= '0;
            settle     <= '0;
            core_key   <= '0;
            core_pi    <= '0;
            r_po       <= '0;
            r_valid    <= 1'b0;
            q_ready    <= 1'b0;
            key_loaded <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            key_cnt    <= key_cnt_n;
            pend       <= pend_n;
            pend_key   <= pend_key_n;
            settle     <= settle_n;
            core_key   <= core_key_n;
            core_pi    <= core_pi_n;
            r_po       <= r_po_n;
            r_valid    <= r_valid_n;
            q_ready    <= q_ready_n;
            key_loaded <= key_loaded_n;
            key_err    <= key_err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        shadow_n     = shadow;
        key_cnt_n    = key_cnt;
        pend_n       = pend;
        pend_key_n   = pend_key;
        settle_n     = settle;
        core_key_n   = core_key;
        core_pi_n    = core_pi;
        r_po_n       = r_po;
        r_valid_n    = r_valid;
        key_loaded_n = key_loaded;
        key_err_n    = key_err;
        commit_ok    = 1'b0;

        // Shift happens before commit so a same-cycle commit sees the new count
        if (key_bit_vld) begin
            shadow_n          = shadow >> 1;
            shadow_n[KEY_W-1] = key_bit;
            if (key_cnt != CNT_W'(KEY_W))
                key_cnt_n = key_cnt + CNT_W'(1);
        end

        if (key_commit) begin
            commit_ok = (key_cnt_n == CNT_W'(KEY_W));
            key_cnt_n = '0;
            if (!commit_ok)
                key_err_n = 1'b1;
        end

        case (state)
            NOKEY: begin
                if (commit_ok) begin
                    core_key_n   = shadow_n;
                    key_loaded_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            IDLE: begin
                if (q_valid && q_ready) begin
                    core_pi_n = q_pi;
                    settle_n  = SET_W'(SETTLE);
                    state_n   = APPLY;
                    // Key must not move under a query that is just launching
                    if (commit_ok) begin
                        pend_n     = 1'b1;
                        pend_key_n = shadow_n;
                    end
                end else if (commit_ok) begin
                    core_key_n   = shadow_n;
                    key_loaded_n = 1'b1;
                end
            end
            APPLY: begin
                if (commit_ok) begin
                    pend_n     = 1'b1;
                    pend_key_n = shadow_n;
                end
                if (settle <= SET_W'(1)) begin
                    settle_n  = '0;
                    r_po_n    = core_po;
                    r_valid_n = 1'b1;
                    state_n   = RESP;
                end else begin
                    settle_n = settle - SET_W'(1);
                end
            end
            RESP: begin
                if (commit_ok) begin
                    pend_n     = 1'b1;
                    pend_key_n = shadow_n;
                end
                if (r_ready) begin
                    r_valid_n = 1'b0;
                    state_n   = IDLE;
                    if (pend_n) begin
                        core_key_n   = pend_key_n;
                        key_loaded_n = 1'b1;
                        pend_n       = 1'b0;
                    end
                end
            end
            default: state_n = NOKEY;
        endcase

        q_ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_c432_key_ctrl.sv
// Scoreboard bench for c432_key_ctrl with a behavioural stand-in for the locked core.
module tb_c432_key_ctrl;

    localparam int unsigned KEY_W  = 2;
    localparam int unsigned PI_W   = 36;
    localparam int unsigned PO_W   = 7;
    localparam int unsigned SETTLE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_bit = 1'b0;
    logic              key_bit_vld = 1'b0;
    logic              key_commit = 1'b0;
    logic              q_valid = 1'b0;
    logic              q_ready;
    logic [PI_W-1:0]   q_pi = '0;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [PO_W-1:0]   r_po;
    logic [PI_W-1:0]   core_pi;
    logic [KEY_W-1:0]  core_key;
    logic [PO_W-1:0]   core_po;
    logic              key_loaded;
    logic              key_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PO_W-1:0]  sb_q[$];
    logic [KEY_W-1:0] exp_key = '0;

    always #5 clk = ~clk;

    function automatic logic [PO_W-1:0] core_fn(input logic [PI_W-1:0] pi, input logic [KEY_W-1:0] k);
        return pi[6:0] ^ pi[35:29] ^ {pi[20:16], k};
    endfunction

    assign core_po = core_fn(core_pi, core_key);

    c432_key_ctrl #(.KEY_W(KEY_W), .PI_W(PI_W), .PO_W(PO_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .key_bit(key_bit), .key_bit_vld(key_bit_vld),
        .key_commit(key_commit), .q_valid(q_valid), .q_ready(q_ready), .q_pi(q_pi),
        .r_valid(r_valid), .r_ready(r_ready), .r_po(r_po), .core_pi(core_pi),
        .core_key(core_key), .core_po(core_po), .key_loaded(key_loaded), .key_err(key_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_core_key", 64'(core_key), 64'd0);
        check("rst_core_pi", 64'(core_pi), 64'd0);
        check("rst_r_po", 64'(r_po), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_q_ready", 64'(q_ready), 64'd0);
        check("rst_key_loaded", 64'(key_loaded), 64'd0);
        check("rst_key_err", 64'(key_err), 64'd0);
        rst = 1'b0;
        exp_key = '0;
    endtask

    task automatic shift_bit(input logic b, input logic with_commit);
        key_bit = b;
        key_bit_vld = 1'b1;
        key_commit = with_commit;
        tick();
        key_bit_vld = 1'b0;
        key_commit = 1'b0;
    endtask

    task automatic commit();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("q_ready_timeout", 64'd0, 64'd1);
    endtask

    // Launch one query; optionally commit a staged key while it is in flight
    task automatic run_query(input logic [PI_W-1:0] pi, input int hold, input bit commit_mid);
        bit ok;
        logic [PO_W-1:0] exp_po;
        logic [KEY_W-1:0] key_at_launch;
        wait_ready(ok);
        if (!ok) return;
        key_at_launch = exp_key;
        q_pi = pi;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        sb_q.push_back(core_fn(pi, exp_key));
        check("core_pi_launch", 64'(core_pi), 64'(pi));
        for (int i = 0; i < int'(SETTLE); i++) begin
            check("r_valid_early", 64'(r_valid), 64'd0);
            check("q_ready_apply", 64'(q_ready), 64'd0);
            key_commit = commit_mid && (i == 0);
            tick();
            key_commit = 1'b0;
        end
        check("r_valid_latency", 64'(r_valid), 64'd1);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        exp_po = sb_q.pop_front();
        check("r_po", 64'(r_po), 64'(exp_po));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_po_hold", 64'(r_po), 64'(exp_po));
            check("r_valid_hold", 64'(r_valid), 64'd1);
            check("q_ready_resp", 64'(q_ready), 64'd0);
            check("core_key_stable", 64'(core_key), 64'(key_at_launch));
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("r_valid_drop", 64'(r_valid), 64'd0);
        check("q_ready_return", 64'(q_ready), 64'd1);
    endtask

    initial begin
        bit ok;
        tick();
        do_reset();

        // No key: queries must be refused
        q_valid = 1'b1;
        q_pi = 36'h123456789;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("nokey_q_ready", 64'(q_ready), 64'd0);
            check("nokey_r_valid", 64'(r_valid), 64'd0);
        end
        q_valid = 1'b0;

        // Short key in NOKEY
        shift_bit(1'b1, 1'b0);
        commit();
        check("short_err", 64'(key_err), 64'd1);
        check("short_loaded", 64'(key_loaded), 64'd0);
        check("short_key", 64'(core_key), 64'd0);
        check("short_q_ready", 64'(q_ready), 64'd0);

        // Bits 1,0 LSB first -> 2'b01
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0);
        commit();
        exp_key = 2'b01;
        check("load_key", 64'(core_key), 64'h1);
        check("load_loaded", 64'(key_loaded), 64'd1);
        check("load_q_ready", 64'(q_ready), 64'd1);
        check("err_sticky", 64'(key_err), 64'd1);

        run_query(36'hA_5A5A_5A5A, 5, 1'b0);
        run_query(36'h0_0000_0000, 0, 1'b0);
        run_query(36'hF_FFFF_FFFF, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            run_query({4'($urandom), $urandom}, int'($urandom_range(0, 3)), 1'b0);

        // Shift and commit in the same cycle use the updated count
        do_reset();
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b1);
        exp_key = 2'b01;
        check("simul_key", 64'(core_key), 64'h1);
        check("simul_loaded", 64'(key_loaded), 64'd1);
        check("simul_err", 64'(key_err), 64'd0);

        // Short key in IDLE keeps the active key
        shift_bit(1'b1, 1'b0);
        commit();
        check("idle_short_err", 64'(key_err), 64'd1);
        check("idle_short_key", 64'(core_key), 64'h1);
        check("idle_short_loaded", 64'(key_loaded), 64'd1);

        // Count saturates: bits 0,1,1 -> 2'b11
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b0);
        commit();
        exp_key = 2'b11;
        check("sat_key", 64'(core_key), 64'h3);
        run_query(36'h3_1415_9265, 2, 1'b0);

        // Commit during APPLY: response uses old key, new key appears back in IDLE
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b1, 1'b0);
        check("staged_no_effect", 64'(core_key), 64'h3);
        run_query(36'h2_7182_8182, 3, 1'b1);
        check("deferred_key", 64'(core_key), 64'h2);
        exp_key = 2'b10;
        run_query(36'h2_7182_8182, 0, 1'b0);

        // Reset mid-APPLY aborts the query
        wait_ready(ok);
        q_pi = 36'h9_8765_4321;
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_key = '0;
        check("abort_loaded", 64'(key_loaded), 64'd0);
        check("abort_key", 64'(core_key), 64'd0);
        check("abort_core_pi", 64'(core_pi), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort_r_valid", 64'(r_valid), 64'd0);
            check("abort_q_ready", 64'(q_ready), 64'd0);
            tick();
        end

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/c432_key_ctrl.md
C432_KEY_CTRL -- requirements
Module: c432_key_ctrl

Interface
REQ-001 SHALL provide parameter KEY_W, default 2, meaning key width driven to the locked core.
REQ-002 SHALL provide parameter PI_W, default 36, meaning core primary-input width.
REQ-003 SHALL provide parameter PO_W, default 7, meaning core primary-output width.
REQ-004 SHALL provide parameter SETTLE, default 2, range 1..15, meaning cycles the core combinational output is allowed to settle before capture.
REQ-005 SHALL provide port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL provide port key_bit, input, 1, meaning serial key data, LSB first.
REQ-008 SHALL provide port key_bit_vld, input, 1, meaning key_bit is valid this cycle.
REQ-009 SHALL provide port key_commit, input, 1, meaning request to transfer the shifted key to the active key register.
REQ-010 SHALL provide port q_valid, input, 1, meaning a query is offered.
REQ-011 SHALL provide port q_ready, output, 1, meaning a query is accepted this cycle.
REQ-012 SHALL provide port q_pi, input, PI_W, meaning the query input pattern.
REQ-013 SHALL provide port r_valid, output, 1, meaning a response is held.
REQ-014 SHALL provide port r_ready, input, 1, meaning the consumer takes the response.
REQ-015 SHALL provide port r_po, output, PO_W, meaning the captured core outputs.
REQ-016 SHALL provide port core_pi, output, PI_W, meaning registered inputs to the locked core.
REQ-017 SHALL provide port core_key, output, KEY_W, meaning registered key inputs to the locked core (s_0 = bit 0, s_1 = bit 1).
REQ-018 SHALL provide port core_po, input, PO_W, meaning the locked core outputs.
REQ-019 SHALL provide port key_loaded, output, 1, meaning a valid key has been committed since reset.
REQ-020 SHALL provide port key_err, output, 1, meaning sticky error: commit with wrong bit count.

Function
REQ-021 SHALL implement FSM states NOKEY, IDLE, APPLY, RESP.
REQ-022 SHALL shift key_bit into a KEY_W shadow register on every key_bit_vld cycle, in any state, and count bits saturating at KEY_W.
REQ-023 On key_commit with bit count == KEY_W, SHALL copy the shadow register to core_key next cycle, set key_loaded, clear the count, and move NOKEY to IDLE.
REQ-024 On key_commit with bit count != KEY_W, SHALL leave core_key unchanged, set key_err, and clear the count.
REQ-025 A key_commit in APPLY or RESP SHALL take effect only at the next entry to IDLE; core_key SHALL be stable for the whole APPLY/RESP span of a query.
REQ-026 Simultaneous key_bit_vld and key_commit SHALL shift first; the commit uses the updated count.
REQ-027 q_ready SHALL be 1 only in IDLE; it SHALL be 0 in NOKEY, APPLY and RESP.
REQ-028 On q_valid and q_ready, SHALL register q_pi to core_pi, load the settle counter with SETTLE, and enter APPLY.
REQ-029 In APPLY the counter SHALL decrement each cycle; when it reaches 0 the block SHALL capture core_po into r_po and enter RESP with r_valid = 1.
REQ-030 Latency from query acceptance to r_valid SHALL be exactly SETTLE+1 cycles.
REQ-031 In RESP, r_valid and r_po SHALL hold until r_ready; on r_ready the block SHALL return to IDLE, with q_ready next asserted on the following cycle.
REQ-032 core_pi SHALL hold its last value outside APPLY.

Reset
REQ-033 On rst the block SHALL enter NOKEY and clear core_key, core_pi, r_po, r_valid, q_ready, key_loaded, key_err, the shadow register, the bit count and the settle counter; all outputs read 0 the cycle after.
REQ-034 rst asserted mid-query or mid-key-shift SHALL abort it with no response emitted; rst SHALL take priority over every other input.

Verification
REQ-035 Reset then q_valid=1 without a key -> q_ready stays 0 and r_valid stays 0 for 20 cycles.
REQ-036 Shift bits 1,0 (LSB first) then commit -> core_key=2'b01, key_loaded=1, q_ready=1 the next cycle.
REQ-037 Shift one bit then commit -> key_err=1, core_key unchanged, key_loaded unchanged.
REQ-038 Key loaded, SETTLE=2, q_pi accepted at cycle t -> r_valid rises at t+3 with r_po equal to core_po sampled that cycle; r_ready held low for 5 cycles -> r_po stable, q_ready 0.
REQ-039 Commit a new key during APPLY -> the current response uses the old key; core_key changes on return to IDLE.
REQ-040 rst pulsed during APPLY -> no r_valid; state NOKEY; key_loaded=0.
